// File: rtl/dadda_mac_accum.sv
// dadda_mac_accum: dot-product accumulator behind a free-running 8x8 Dadda
// multiplier. A tag pipe tracks which multiplier output cycles carry real
// products. Vector results are queued in a 2-entry FIFO. Credits throttle
// upstream issue so that a completed vector always finds a free FIFO slot.
module dadda_mac_accum #(
    parameter int MUL_LAT = 6,   // multiplier latency in cycles
    parameter int ACC_W   = 24,  // accumulator / result width, >= 16
    parameter int CNT_W   = 8    // beat counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [15:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int SUM_W = ACC_W + 1;
    // Wide enough to hold the FIFO occupancy plus every last tag in flight.
    localparam int LW    = $clog2(MUL_LAT + 3);

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } result_t;

    logic               rst_q;
    logic               accept;
    logic [MUL_LAT-1:0] tag_valid;
    logic [MUL_LAT-1:0] tag_last;
    logic               tag_out_valid;
    logic               tag_out_last;

    logic               first;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic [ACC_W-1:0]   base;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    result_t            mem [2];
    result_t            head;
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         fifo_count;
    logic               push;
    logic               pop;

    logic [LW-1:0]      lasts_in_flight;
    logic [LW-1:0]      used;

    assign accept        = in_valid && in_ready;
    assign tag_out_valid = tag_valid[MUL_LAT-1];
    assign tag_out_last  = tag_last[MUL_LAT-1];
    assign push          = tag_out_valid && tag_out_last;
    assign out_valid     = (fifo_count != 2'd0);
    assign pop           = out_valid && out_ready;

    // Registered copy of reset, holding off issue for one cycle after reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        rst_q <= rst;
    end

    // Tag pipe: mirrors the multiplier latency, shifts every cycle, never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            for (int i = MUL_LAT - 1; i > 0; i--) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
            tag_valid[0] <= accept;
            tag_last[0]  <= in_last;
        end
    end

    // Accumulator datapath: restart from zero on the first beat of a vector.
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every
        // path (here unconditionally) so no latch is inferred.
        base     = first ? '0 : acc;
        sum      = {1'b0, base} + SUM_W'(prod);
        acc_next = sum[ACC_W-1:0];
        ovf_next = (first ? 1'b0 : ovf) | sum[ACC_W];
        if (first)
            cnt_next = CNT_W'(1);
        else if (&cnt)
            cnt_next = cnt;
        else
            cnt_next = cnt + CNT_W'(1);
    end

    // Accumulator state: updated only on cycles whose product is real.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (tag_out_valid) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            first <= tag_out_last;
        end
    end

    // Result FIFO control: pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Result FIFO storage. When full, a push lands in the slot being popped.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is reset instead and
        // the outputs are gated by out_valid, so stale entries never show.
        if (push)
            mem[wr_ptr] <= '{acc: acc_next, cnt: cnt_next, ovf: ovf_next};
    end

    assign head      = mem[rd_ptr];
    assign out_acc   = out_valid ? head.acc : '0;
    assign out_count = out_valid ? head.cnt : '0;
    assign out_ovf   = out_valid ? head.ovf : 1'b0;

    // Credit check: two slots minus queued results minus vectors still in flight.
    always_comb begin
        lasts_in_flight = '0;
        for (int i = 0; i < MUL_LAT; i++)
            lasts_in_flight = lasts_in_flight + LW'(tag_valid[i] & tag_last[i]);
        used     = LW'(fifo_count) + lasts_in_flight;
        in_ready = (used < LW'(2)) && !rst_q;
    end

endmodule

// File: tb/tb_dadda_mac_accum.sv
// Directed and random-stimulus bench for dadda_mac_accum. A behavioural
// multiplier pipe feeds prod and emits junk on cycles without an accepted beat.
module tb_dadda_mac_accum;

    localparam int MUL_LAT = 6;
    localparam int ACC_W   = 24;
    localparam int CNT_W   = 8;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [15:0]      prod;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    logic [7:0]       a = 8'd0;
    logic [7:0]       b = 8'd0;
    logic [15:0]      mp [MUL_LAT];
    logic             rand_phase = 1'b0;
    logic             rdy_dir = 1'b0;
    logic             rdy_rand = 1'b0;
    res_t             exp_q [$];

    int checks = 0;
    int errors = 0;

    assign out_ready = rand_phase ? rdy_rand : rdy_dir;
    assign prod      = mp[MUL_LAT-1];

    dadda_mac_accum #(.MUL_LAT(MUL_LAT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .prod      (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Multiplier model: product of an accepted beat appears MUL_LAT cycles later.
    always @(posedge clk) begin
        mp[0] <= (in_valid && in_ready) ? 16'(a) * 16'(b) : 16'hBEEF;
        for (int j = 1; j < MUL_LAT; j++)
            mp[j] <= mp[j-1];
    end

    // Random consumer back-pressure.
    always @(posedge clk)
        rdy_rand <= ($urandom_range(0, 9) < 7);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result scoreboard for the random phase.
    always @(negedge clk) begin
        if (rand_phase && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(exp_q.size()), 1);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check("rand_acc", 32'(out_acc), 32'(r.acc));
                check("rand_count", 32'(out_count), 32'(r.cnt));
                check("rand_ovf", 32'(out_ovf), 32'(r.ovf));
            end
        end
    end

    // FIFO must never receive a push while full unless it also pops.
    always @(negedge clk) begin
        if (!rst && dut.push)
            check("fifo_no_overflow", 32'(!(dut.fifo_count == 2'd2 && !dut.pop)), 1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic l);
        int n = 0;
        a = x;
        b = y;
        in_last = l;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            step();
            n++;
        end
        if (n >= 500)
            check("send_timeout", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (!out_valid && n < bound) begin
            step();
            n++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    initial begin
        bit seen;
        int gaps;

        // Reset
        step();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_acc", 32'(out_acc), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        step();
        rst = 1'b0;
        check("rst_in_ready_held", 32'(in_ready), 0);
        step();
        check("in_ready_after_rst", 32'(in_ready), 1);

        // Single beat 3x5, latency and one-cycle out_valid
        rdy_dir = 1'b1;
        a = 8'd3; b = 8'd5; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen |= out_valid;
            step();
        end
        seen |= out_valid;
        check("single_early_valid", 32'(seen), 0);
        step();
        check("single_valid", 32'(out_valid), 1);
        check("single_acc", 32'(out_acc), 15);
        check("single_count", 32'(out_count), 1);
        check("single_ovf", 32'(out_ovf), 0);
        step();
        check("single_valid_drop", 32'(out_valid), 0);

        // Four 255x255 beats with idle gaps
        for (int i = 0; i < 4; i++) begin
            send(8'd255, 8'd255, i == 3);
            for (int g = 0; g <= i; g++)
                step();
        end
        wait_valid("gap_valid", 50);
        check("gap_acc", 32'(out_acc), 260100);
        check("gap_count", 32'(out_count), 4);
        check("gap_ovf", 32'(out_ovf), 0);
        step();

        // 300 beats: wraps the accumulator and saturates the counter
        for (int i = 0; i < 300; i++)
            send(8'd255, 8'd255, i == 299);
        wait_valid("long_valid", 50);
        check("long_acc", 32'(out_acc), 2730284);
        check("long_count", 32'(out_count), 255);
        check("long_ovf", 32'(out_ovf), 1);
        step();

        // Back-pressure: two results fill the FIFO, the third beat is held
        rdy_dir = 1'b0;
        send(8'd1, 8'd1, 1'b1);
        send(8'd2, 8'd2, 1'b1);
        check("bp_in_ready_low", 32'(in_ready), 0);
        a = 8'd3; b = 8'd3; in_last = 1'b1; in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= in_ready;
            step();
        end
        check("bp_in_ready_held", 32'(seen), 0);
        check("bp_head_valid", 32'(out_valid), 1);
        check("bp_head_acc", 32'(out_acc), 1);
        step();
        step();
        check("bp_head_stable", 32'(out_acc), 1);
        check("bp_head_count", 32'(out_count), 1);
        rdy_dir = 1'b1;
        check("bp_in_ready_before_pop", 32'(in_ready), 0);
        step();
        check("bp_in_ready_after_pop", 32'(in_ready), 1);
        check("bp_second_acc", 32'(out_acc), 4);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid("bp_third_valid", 50);
        check("bp_third_acc", 32'(out_acc), 9);
        step();

        // Reset with two beats of a three-beat vector in flight
        send(8'd5, 8'd7, 1'b0);
        send(8'd6, 8'd7, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_acc", 32'(out_acc), 0);
        check("midrst_out_count", 32'(out_count), 0);
        check("midrst_out_ovf", 32'(out_ovf), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        step();
        check("midrst_in_ready_back", 32'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen |= out_valid;
            step();
        end
        check("midrst_no_result", 32'(seen), 0);
        send(8'd2, 8'd2, 1'b1);
        wait_valid("midrst_next_valid", 50);
        check("midrst_next_acc", 32'(out_acc), 4);
        check("midrst_next_count", 32'(out_count), 1);
        check("midrst_next_ovf", 32'(out_ovf), 0);
        step();

        // Random vectors against a reference model
        rand_phase = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int len;
            logic [ACC_W-1:0] m_acc;
            logic [CNT_W-1:0] m_cnt;
            logic m_ovf;
            logic [ACC_W:0] s;
            len = $urandom_range(1, 20);
            m_acc = '0;
            m_cnt = '0;
            m_ovf = 1'b0;
            for (int i = 0; i < len; i++) begin
                logic [7:0] x;
                logic [7:0] y;
                x = 8'($urandom_range(0, 255));
                y = 8'($urandom_range(0, 255));
                s = {1'b0, m_acc} + (ACC_W + 1)'(16'(x) * 16'(y));
                m_ovf = m_ovf | s[ACC_W];
                m_acc = s[ACC_W-1:0];
                m_cnt = (m_cnt == '1) ? m_cnt : m_cnt + 1'b1;
                send(x, y, i == len - 1);
                if ($urandom_range(0, 3) == 0)
                    step();
            end
            exp_q.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf});
        end
        gaps = 0;
        while (exp_q.size() != 0 && gaps < 1000) begin
            step();
            gaps++;
        end
        check("rand_drained", 32'(exp_q.size()), 0);
        rand_phase = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
